ssm_y_collector: RTL and testbench
==================================

// Module: ssm_y_collector
// PURPOSE
//  Receive end of the SSM block result stream. Captures each y_final scalar from SSMBLOCK_TOP.
//  Files each result at its (h,p) slot, addr = h*P + p, in an H*P result RAM.
//  The tile issuer pushes one (h,p) tag when it issues the first tile of a group.
//  Results return in issue order, so a tag FIFO carries the index across the pipeline latency.
//  Host/bench reads results back through a 1-cycle-latency read port.
// PARAMETERS
//  DW        16    result word width
//  H         24    number of heads
//  P         64    head dim
//  TAG_DEPTH 8     tag FIFO entries (>= groups in flight through SSMBLOCK_TOP)
//  HW        $clog2(H)    tag h width (5)
//  PW        $clog2(P)    tag p width (6)
//  AW        $clog2(H*P)  RAM address width (11)
// PORTS
//  clk           in   1      clock, all logic on rising edge
//  rst           in   1      synchronous, active-high reset
//  start_i       in   1      begin/restart a collection pass (1-cycle pulse)
//  tag_valid_i   in   1      issuer presents (h,p) tag
//  tag_ready_o   out  1      tag FIFO accepts
//  tag_h_i       in   HW     head index of issued group
//  tag_p_i       in   PW     p index of issued group
//  y_valid_i     in   1      = SSMBLOCK_TOP y_final_valid_o; no back-pressure
//  y_i           in   DW     = SSMBLOCK_TOP y_final_o
//  rd_en_i       in   1      read request
//  rd_addr_i     in   AW     read address, h*P+p
//  rd_data_o     out  DW     read data
//  rd_valid_o    out  1      rd_data_o valid
//  count_o       out  AW+1   distinct slots written this pass
//  done_o        out  1      all H*P slots written; sticky
//  err_orphan_o  out  1      sticky: y arrived with no tag, y dropped
//  err_range_o   out  1      sticky: popped tag has h>=H or p>=P, write dropped
//  err_dup_o     out  1      sticky: slot written twice; overwrite still performed
// BEHAVIOUR
//  Reset values: state=IDLE, FIFO empty, written-bitmap cleared, tag_ready_o=0, rd_valid_o=0.
//    Also count_o=0, done_o=0, all err_*=0, rd_data_o=0. RAM contents are not reset.
//  FSM IDLE -> COLLECT on start_i.
//    COLLECT -> DONE in the cycle after count reaches H*P.
//    DONE -> COLLECT on start_i. rst -> IDLE from any state.
//  start_i (any state, including mid-pass): flush FIFO, clear bitmap/count/done/err_*; RAM keeps data.
//    start_i wins over a same-cycle y_valid_i or tag push; both are dropped, no error raised.
//  tag_ready_o = (state==COLLECT) && !fifo_full.
//    No pop-through on full: push is refused while full even if a pop occurs in the same cycle.
//  y_valid_i in COLLECT with FIFO non-empty: pop head tag.
//    The RAM write at the tag address lands at the next edge.
//    If the bitmap bit is clear, set it and count_o+=1; if already set, set err_dup_o.
//  y_valid_i with FIFO empty: err_orphan_o set, y dropped.
//    This includes the same cycle as a push into an empty FIFO (no bypass).
//  y_valid_i in IDLE is ignored, no error. In DONE it is handled as in COLLECT, so orphans are flagged.
//  Simultaneous push and pop in COLLECT with FIFO not full: both occur, occupancy unchanged.
//  Out-of-range popped tag: tag consumed, no RAM write, err_range_o set, count unchanged.
//  Address arithmetic: addr = h*P + p in AW bits (P power of two -> {h,p} concatenation legal).
//  Read port: rd_valid_o = rd_en_i delayed 1 cycle; rd_data_o = RAM[rd_addr_i] registered.
//    Read and write to the same address in one cycle returns the old data.
//    rd_addr_i >= H*P returns 0.
//  Throughput: one y per cycle sustained; no internal stall ever (y has no ready).
// STRUCTURE
//  Shared package ssm_pkg: DW, H, P, N, N_TILE; HW/PW/AW localparams.
//    Also function hp_addr(h,p) and typedef hp_tag_t {h,p}, common with the tile issuer.
//  Sub-module: ssm_tag_fifo, a synchronous FIFO of width HW+PW and depth TAG_DEPTH.
//    Provides full/empty and a sync flush.
//  Top holds the FSM, bitmap (H*P bits), counter, and the inferred 1R1W RAM.
// TESTING
//  1. rst, start, push 1536 tags in h-major order, y=addr after 40-cycle delay.
//     Expect count_o=1536, done_o=1, readback RAM[a]==a for all a, no err_*.
//  2. Tags (3,5),(3,6); y=0x1111,0x2222 back-to-back.
//     Expect RAM[197]=0x1111, RAM[198]=0x2222, count_o=2.
//  3. y_valid_i with FIFO empty -> err_orphan_o=1, count_o unchanged.
//     Same for y in the push cycle into an empty FIFO.
//  4. Fill 8 tags with no y: tag_ready_o=0; 9th tag held until one y pops, then accepted.
//  5. Tag (2,7) twice, y=0xAAAA then 0xBBBB.
//     Expect err_dup_o=1, RAM[135]=0xBBBB, count_o=1. Tag h=30 -> err_range_o=1, no write.
//  6. start_i mid-pass after 100 results.
//     Expect count_o=0, FIFO empty, errors cleared, RAM[0..99] still readable; rst mid-pass -> IDLE.

Source files
------------

// File: rtl/ssm_pkg.sv
// rtl/ssm_pkg.sv - shared SSM constants, (h,p) tag type and slot address helper
package ssm_pkg;

  localparam int DW     = 16;
  localparam int H      = 24;
  localparam int P      = 64;
  localparam int N      = 16;
  localparam int N_TILE = 16;

  localparam int HW = $clog2(H);
  localparam int PW = $clog2(P);
  localparam int AW = $clog2(H * P);

  typedef struct packed {
    logic [HW-1:0] h;
    logic [PW-1:0] p;
  } hp_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } col_state_t;

  // P is a power of two, so h*P+p is just {h,p}.
  function automatic logic [AW-1:0] hp_addr(input logic [HW-1:0] h, input logic [PW-1:0] p);
    return AW'({h, p});
  endfunction

endpackage

// File: rtl/ssm_tag_fifo.sv
// rtl/ssm_tag_fifo.sv - synchronous show-ahead tag FIFO with sync flush
module ssm_tag_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] ptr);
    return (ptr == PTRW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ssm_y_collector.sv
// rtl/ssm_y_collector.sv - files returning y_final scalars into an H*P result RAM by issue-order tag
module ssm_y_collector
  import ssm_pkg::*;
#(
  parameter int TAG_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          tag_valid_i,
  output logic          tag_ready_o,
  input  logic [HW-1:0] tag_h_i,
  input  logic [PW-1:0] tag_p_i,
  input  logic          y_valid_i,
  input  logic [DW-1:0] y_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic [AW:0]   count_o,
  output logic          done_o,
  output logic          err_orphan_o,
  output logic          err_range_o,
  output logic          err_dup_o
);

  localparam int NSLOT = H * P;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(NSLOT);

  col_state_t       state;
  col_state_t       state_nx;
  hp_tag_t          push_tag;
  hp_tag_t          head_tag;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             orphan;
  logic             in_range;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [NSLOT-1:0] written;
  logic [DW-1:0]    ram [NSLOT];

  assign push_tag.h = tag_h_i;
  assign push_tag.p = tag_p_i;

  ssm_tag_fifo #(
    .W     ($bits(hp_tag_t)),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start_i),
    .push  (push),
    .pop   (pop),
    .wdata (push_tag),
    .rdata (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // start_i overrides any same-cycle push or y so a restart never inherits stale traffic.
  always_comb begin
    state_nx    = state;
    tag_ready_o = (state == ST_COLLECT) && !fifo_full;
    push        = tag_valid_i && tag_ready_o && !start_i;
    pop         = y_valid_i && (state != ST_IDLE) && !fifo_empty && !start_i;
    orphan      = y_valid_i && (state != ST_IDLE) && fifo_empty && !start_i;
    in_range    = (int'(head_tag.h) < H) && (int'(head_tag.p) < P);
    waddr       = hp_addr(head_tag.h, head_tag.p);
    we          = pop && in_range;

    if (start_i) begin
      state_nx = ST_COLLECT;
    end else begin
      case (state)
        ST_COLLECT: if (count_o == FULL_CNT) state_nx = ST_DONE;
        default:    state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      written      <= '0;
      count_o      <= '0;
      done_o       <= 1'b0;
      err_orphan_o <= 1'b0;
      err_range_o  <= 1'b0;
      err_dup_o    <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_i) begin
        written      <= '0;
        count_o      <= '0;
        done_o       <= 1'b0;
        err_orphan_o <= 1'b0;
        err_range_o  <= 1'b0;
        err_dup_o    <= 1'b0;
      end else begin
        if (we) begin
          if (written[waddr]) begin
            err_dup_o <= 1'b1;
          end else begin
            written[waddr] <= 1'b1;
            count_o        <= count_o + 1'b1;
          end
        end
        if (pop && !in_range) err_range_o  <= 1'b1;
        if (orphan)           err_orphan_o <= 1'b1;
        if (count_o == FULL_CNT) done_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= y_i;
  end

  // Registered read: a same-address write in this cycle is not yet visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= (int'(rd_addr_i) < NSLOT) ? ram[rd_addr_i] : '0;
    end
  end

endmodule

// File: tb/tb_ssm_y_collector.sv
// tb/tb_ssm_y_collector.sv - directed scoreboard bench for ssm_y_collector
module tb_ssm_y_collector;
  import ssm_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          tag_valid;
  logic          tag_ready;
  logic [HW-1:0] tag_h;
  logic [PW-1:0] tag_p;
  logic          y_valid;
  logic [DW-1:0] y;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          done;
  logic          err_orphan;
  logic          err_range;
  logic          err_dup;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  int            addr_q[$];

  always #5 clk = ~clk;

  ssm_y_collector dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .tag_valid_i  (tag_valid),
    .tag_ready_o  (tag_ready),
    .tag_h_i      (tag_h),
    .tag_p_i      (tag_p),
    .y_valid_i    (y_valid),
    .y_i          (y),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .count_o      (count),
    .done_o       (done),
    .err_orphan_o (err_orphan),
    .err_range_o  (err_range),
    .err_dup_o    (err_dup)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] e);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    exp_q.push_back(e);
    addr_q.push_back(a);
    step();
    rd_en = 1'b0;
  endtask

  task automatic push_tag(input logic [HW-1:0] h, input logic [PW-1:0] p);
    tag_valid = 1'b1;
    tag_h     = h;
    tag_p     = p;
    step();
    tag_valid = 1'b0;
  endtask

  task automatic send_y(input logic [DW-1:0] v);
    y_valid = 1'b1;
    y       = v;
    step();
    y_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Issuer model: push slots first..first+n-1 as the FIFO allows; each y returns dly cycles after its tag.
  task automatic run_tags(input int first, input int n, input int dly, input logic [DW-1:0] base);
    int            due[$];
    logic [DW-1:0] val[$];
    int            cyc = 0;
    int            issued = 0;
    int            a;
    while ((issued < n || due.size() > 0) && cyc < 20000) begin
      a         = first + issued;
      tag_valid = (issued < n);
      tag_h     = HW'(a / P);
      tag_p     = PW'(a % P);
      if (due.size() > 0 && due[0] == cyc) begin
        y_valid = 1'b1;
        y       = val.pop_front();
        void'(due.pop_front());
      end else begin
        y_valid = 1'b0;
      end
      if (tag_valid && tag_ready) begin
        due.push_back(cyc + dly);
        val.push_back(base + DW'(a));
        issued++;
      end
      step();
      cyc++;
    end
    tag_valid = 1'b0;
    y_valid   = 1'b0;
    chk("run_tags_in_budget", 32'(cyc < 20000), 32'd1);
  endtask

  always @(negedge clk) begin
    logic [DW-1:0] e;
    int            a;
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_spurious", 32'(rd_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        chk($sformatf("rd[%0d]", a), 32'(rd_data), 32'(e));
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; tag_valid = 1'b0; tag_h = '0; tag_p = '0;
    y_valid = 1'b0; y = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_tag_ready", 32'(tag_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_errs", 32'({err_orphan, err_range, err_dup}), 32'd0);

    // y in IDLE is ignored
    send_y(16'h1234);
    chk("idle_y_no_orphan", 32'(err_orphan), 32'd0);

    // 1: full pass, h-major, y = addr after 40 cycles
    pulse_start();
    chk("collect_tag_ready", 32'(tag_ready), 32'd1);
    run_tags(0, H * P, 40, 16'h0000);
    repeat (3) step();
    chk("t1_count", 32'(count), 32'd1536);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_errs", 32'({err_orphan, err_range, err_dup}), 32'd0);
    for (int a = 0; a < H * P; a++) rd(a, DW'(a));
    rd(1536, 16'h0000);
    rd(2047, 16'h0000);

    // 2: two tags, back-to-back ys
    pulse_start();
    chk("t2_count_cleared", 32'(count), 32'd0);
    chk("t2_done_cleared", 32'(done), 32'd0);
    push_tag(5'd3, 6'd5);
    push_tag(5'd3, 6'd6);
    send_y(16'h1111);
    send_y(16'h2222);
    chk("t2_count", 32'(count), 32'd2);
    rd(197, 16'h1111);
    rd(198, 16'h2222);

    // 3: orphans
    pulse_start();
    send_y(16'hDEAD);
    chk("t3_orphan", 32'(err_orphan), 32'd1);
    chk("t3_count", 32'(count), 32'd0);
    pulse_start();
    chk("t3_orphan_cleared", 32'(err_orphan), 32'd0);
    tag_valid = 1'b1; tag_h = 5'd0; tag_p = 6'd1;
    y_valid = 1'b1; y = 16'hBEEF;
    step();
    tag_valid = 1'b0; y_valid = 1'b0;
    chk("t3_orphan_push_cycle", 32'(err_orphan), 32'd1);
    chk("t3_count_push_cycle", 32'(count), 32'd0);

    // 4: full FIFO refuses push even with a same-cycle pop
    pulse_start();
    for (int i = 0; i < 8; i++) push_tag(5'd0, PW'(i));
    chk("t4_full_not_ready", 32'(tag_ready), 32'd0);
    tag_valid = 1'b1; tag_h = 5'd1; tag_p = 6'd0;
    y_valid = 1'b1; y = 16'h4000;
    step();
    y_valid = 1'b0;
    chk("t4_no_pop_through", 32'(tag_ready), 32'd1);
    step();
    tag_valid = 1'b0;
    chk("t4_ninth_accepted_full", 32'(tag_ready), 32'd0);
    for (int i = 1; i <= 8; i++) send_y(16'h4000 + DW'(i));
    chk("t4_count", 32'(count), 32'd9);
    chk("t4_no_orphan", 32'(err_orphan), 32'd0);
    rd(0, 16'h4000);
    rd(7, 16'h4007);
    rd(64, 16'h4008);

    // 5: duplicate and out-of-range tags
    pulse_start();
    push_tag(5'd2, 6'd7);
    push_tag(5'd2, 6'd7);
    push_tag(5'd30, 6'd0);
    send_y(16'hAAAA);
    chk("t5_no_dup_yet", 32'(err_dup), 32'd0);
    send_y(16'hBBBB);
    chk("t5_dup", 32'(err_dup), 32'd1);
    send_y(16'h5555);
    chk("t5_range", 32'(err_range), 32'd1);
    chk("t5_count", 32'(count), 32'd1);
    rd(135, 16'hBBBB);

    // 6: restart mid-pass, then reset mid-pass
    pulse_start();
    run_tags(0, 100, 3, 16'hC000);
    push_tag(5'd31, 6'd0);
    push_tag(5'd3, 6'd9);
    send_y(16'h7777);
    chk("t6_range_before", 32'(err_range), 32'd1);
    chk("t6_count_before", 32'(count), 32'd100);
    start = 1'b1;
    tag_valid = 1'b1; tag_h = 5'd4; tag_p = 6'd4;
    y_valid = 1'b1; y = 16'h9999;
    step();
    start = 1'b0; tag_valid = 1'b0; y_valid = 1'b0;
    chk("t6_count_cleared", 32'(count), 32'd0);
    chk("t6_errs_cleared", 32'({err_orphan, err_range, err_dup}), 32'd0);
    chk("t6_done_cleared", 32'(done), 32'd0);
    chk("t6_ready_after_flush", 32'(tag_ready), 32'd1);
    send_y(16'h8888);
    chk("t6_fifo_flushed", 32'(err_orphan), 32'd1);
    chk("t6_count_after_orphan", 32'(count), 32'd0);
    for (int a = 0; a < 100; a++) rd(a, 16'hC000 + DW'(a));
    rd(200 - 3 * 0, 16'h00C8);

    pulse_start();
    push_tag(5'd1, 6'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_idle_ready", 32'(tag_ready), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    send_y(16'h4321);
    chk("t6_rst_idle_y_ignored", 32'(err_orphan), 32'd0);

    repeat (3) step();
    chk("rd_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
